// File: rtl/vproc_div_iter.sv
// Iterative radix-2 restoring divider for 32-bit DIV/DIVU/REM/REMU vector elements.
// The divisor is MSB-aligned through the external shift/CLZ helper, so an operation takes clz(|b|)+1 iterations.
module vproc_div_iter #(
    parameter int unsigned ID_W = 4
) (
    input  logic            clk_i,
    input  logic            sync_rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [31:0]     op_a_i,
    input  logic [31:0]     op_b_i,
    input  logic [ID_W-1:0] id_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     result_o,
    output logic [ID_W-1:0] id_o,
    input  logic            flush_i,
    output logic [31:0]     muldiv_operand_b_o,
    output logic            div_clz_en_o,
    output logic [31:0]     div_clz_data_rev_o,
    input  logic [5:0]      div_clz_result_i,
    output logic            div_shift_en_o,
    output logic [5:0]      div_shift_amt_o,
    input  logic [31:0]     div_op_b_shifted_i,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        DIVIDE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     a_raw_q;
    logic [31:0]     a_abs_q;
    logic [31:0]     b_abs_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic [31:0]     divisor_q;
    logic [31:0]     rem_q;
    logic [31:0]     quot_q;
    logic [4:0]      cnt_q;

    logic            signed_op;
    logic [31:0]     a_abs;
    logic [31:0]     b_abs;
    logic            sub_ok;
    logic [31:0]     rem_nxt;
    logic [31:0]     quot_nxt;
    logic [31:0]     quot_fix;
    logic [31:0]     rem_fix;
    logic [31:0]     b_rev;
    logic            in_init;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload stay stable until that edge.
    assign in_ready_o = (state == IDLE);
    assign state_o    = state;
    assign in_init    = (state == INIT);

    assign signed_op = op_i[0];
    assign a_abs     = (signed_op && op_a_i[31]) ? -op_a_i : op_a_i;
    assign b_abs     = (signed_op && op_b_i[31]) ? -op_b_i : op_b_i;

    always_comb begin
        b_rev = '0;
        for (int i = 0; i < 32; i++) begin
            b_rev[i] = b_abs_q[31-i];
        end
    end

    always_comb begin
        sub_ok   = (rem_q >= divisor_q);
        rem_nxt  = sub_ok ? (rem_q - divisor_q) : rem_q;
        quot_nxt = {quot_q[30:0], sub_ok};
        quot_fix = (sign_a_q ^ sign_b_q) ? -quot_nxt : quot_nxt;
        rem_fix  = sign_a_q ? -rem_nxt : rem_nxt;
    end

    // Helper inputs are only meaningful in INIT; zero them elsewhere to keep the helper quiet.
    assign div_clz_en_o       = in_init;
    assign div_shift_en_o     = in_init;
    assign muldiv_operand_b_o = in_init ? b_abs_q : '0;
    assign div_clz_data_rev_o = in_init ? b_rev : '0;
    assign div_shift_amt_o    = in_init ? div_clz_result_i : '0;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state       <= IDLE;
            op_q        <= '0;
            id_q        <= '0;
            a_raw_q     <= '0;
            a_abs_q     <= '0;
            b_abs_q     <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            id_o        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && !flush_i) begin
                        op_q     <= op_i;
                        id_q     <= id_i;
                        a_raw_q  <= op_a_i;
                        a_abs_q  <= a_abs;
                        b_abs_q  <= b_abs;
                        sign_a_q <= signed_op & op_a_i[31];
                        sign_b_q <= signed_op & op_b_i[31];
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (div_clz_result_i[5]) begin
                        // Divide by zero: RISC-V defined results, no sign fix-up.
                        result_o    <= op_q[1] ? a_raw_q : 32'hFFFF_FFFF;
                        id_o        <= id_q;
                        out_valid_o <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        divisor_q <= div_op_b_shifted_i;
                        rem_q     <= a_abs_q;
                        quot_q    <= '0;
                        cnt_q     <= div_clz_result_i[4:0];
                        state     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem_q     <= rem_nxt;
                        quot_q    <= quot_nxt;
                        divisor_q <= divisor_q >> 1;
                        if (cnt_q == 5'd0) begin
                            result_o    <= op_q[1] ? rem_fix : quot_fix;
                            id_o        <= id_q;
                            out_valid_o <= 1'b1;
                            state       <= FINISH;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                FINISH: begin
                    if (flush_i || out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vproc_div_iter.sv
// Bench for vproc_div_iter: directed and random divisions against an arithmetic model,
// plus backpressure, flush and mid-operation reset scenarios.
module tb_vproc_div_iter;
    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready_o;
    logic [1:0]      op = '0;
    logic [31:0]     op_a = '0;
    logic [31:0]     op_b = '0;
    logic [ID_W-1:0] id = '0;
    logic            out_valid_o;
    logic            out_ready = 1'b1;
    logic [31:0]     result_o;
    logic [ID_W-1:0] id_o;
    logic            flush = 1'b0;
    logic [31:0]     muldiv_operand_b_o;
    logic            div_clz_en_o;
    logic [31:0]     div_clz_data_rev_o;
    logic [5:0]      clz_res;
    logic            div_shift_en_o;
    logic [5:0]      div_shift_amt_o;
    logic [31:0]     b_shifted;
    logic [1:0]      state_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    vproc_div_iter #(.ID_W(ID_W)) dut (
        .clk_i(clk), .sync_rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .op_i(op), .op_a_i(op_a), .op_b_i(op_b), .id_i(id),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .result_o(result_o), .id_o(id_o), .flush_i(flush),
        .muldiv_operand_b_o(muldiv_operand_b_o),
        .div_clz_en_o(div_clz_en_o), .div_clz_data_rev_o(div_clz_data_rev_o),
        .div_clz_result_i(clz_res),
        .div_shift_en_o(div_shift_en_o), .div_shift_amt_o(div_shift_amt_o),
        .div_op_b_shifted_i(b_shifted), .state_o(state_o)
    );

    // Combinational helper: trailing zeros of the reversed divisor, and the shifter.
    always_comb begin
        clz_res = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (div_clz_data_rev_o[i]) clz_res = 6'(i);
        end
        b_shifted = muldiv_operand_b_o << div_shift_amt_o;
    end

    function automatic logic [31:0] ref_result(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return f_op[1] ? a : 32'hFFFF_FFFF;
        if (f_op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return f_op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f_op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] f_op, input logic [31:0] b);
        logic [31:0] mag;
        if (b == 32'd0) return 2;
        mag = (f_op[0] && b[31]) ? -b : b;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) return (31 - i) + 3;
        end
        return 35;
    endfunction

    task automatic drive_req(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b, input logic [ID_W-1:0] f_id);
        in_valid = 1'b1;
        op = f_op;
        op_a = a;
        op_b = b;
        id = f_id;
    endtask

    // Runs one request to completion; cycle 0 is the accept edge.
    task automatic do_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                         input logic [ID_W-1:0] f_id, input int stall, input string name);
        logic [31:0] exp;
        int exp_lat;
        int cyc;
        exp_q.push_back(ref_result(f_op, a, b));
        exp_lat = ref_latency(f_op, b);
        @(negedge clk);
        cyc = 0;
        while (!in_ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        drive_req(f_op, a, b, f_id);
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
        end
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h (op=%b a=%h b=%h)", name, result_o, exp, f_op, a, b);
        end
        checks++;
        if (id_o !== f_id) begin
            errors++;
            $display("FAIL %s id: got %h, expected %h", name, id_o, f_id);
        end
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, expected 0/1", name, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || result_o !== 32'd0 || id_o !== '0 || in_ready_o !== 1'b1 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset: valid=%b result=%h id=%h ready=%b state=%0d, expected 0/0/0/1/0",
                     out_valid_o, result_o, id_o, in_ready_o, state_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready: got %b, expected 1", in_ready_o);
        end
    endtask

    task automatic test_directed();
        do_op(2'b00, 32'd100, 32'd7, 4'h1, 0, "divu_100_7");
        do_op(2'b10, 32'd100, 32'd7, 4'h2, 0, "remu_100_7");
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 4'h3, 0, "div_m7_2");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 4'h4, 0, "rem_m7_2");
        do_op(2'b01, 32'd7, 32'hFFFF_FFFE, 4'h5, 0, "div_7_m2");
        do_op(2'b00, 32'd5, 32'd0, 4'h6, 0, "divu_by_zero");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 4'h7, 0, "rem_by_zero");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 0, "div_overflow");
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 1, "rem_overflow");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            do_op(2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int cyc;
        exp_q.push_back(ref_result(2'b00, 32'd1000, 32'd3));
        exp_q.push_back(ref_result(2'b10, 32'd1000, 32'd3));
        @(negedge clk);
        drive_req(2'b00, 32'd1000, 32'd3, 4'hA);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_req(2'b10, 32'd1000, 32'd3, 4'h5);
        cyc = 1;
        while (!out_valid_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (result_o !== exp || id_o !== 4'hA || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure hold %0d: result=%h id=%h valid=%b ready=%b, expected %h/a/1/0",
                         k, result_o, id_o, out_valid_o, in_ready_o, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: valid=%b ready=%b, expected 0/1", out_valid_o, in_ready_o);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL second accept: ready=%b, expected 0", in_ready_o);
        end
        cyc = 1;
        while (!out_valid_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (result_o !== exp || id_o !== 4'h5) begin
            errors++;
            $display("FAIL second result: result=%h id=%h, expected %h/5", result_o, id_o, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        drive_req(2'b00, 32'hFFFF_FFFF, 32'd1, 4'h3);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (state_o !== 2'd0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush idle: state=%0d ready=%b valid=%b, expected 0/1/0", state_o, in_ready_o, out_valid_o);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush no_result: got %0d valid cycles, expected 0", seen);
        end
        drive_req(2'b00, 32'd5, 32'd0, 4'h2);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (10) begin
            if (out_valid_o || !in_ready_o) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush blocks accept: got %0d busy cycles, expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        drive_req(2'b00, 32'hFFFF_FFFF, 32'd1, 4'h7);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || result_o !== 32'd0 || id_o !== '0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b result=%h id=%h ready=%b, expected 0/0/0/1",
                     out_valid_o, result_o, id_o, in_ready_o);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid no_result: got %0d valid cycles, expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
